// File: rtl/turn_seq_fsm.sv
// Sequential turn-signal controller: N lamps per side, hazard flash, and a step prescaler.
// Optional brake overlay is enabled with the TURN_SEQ_BRAKE_EN macro.
module turn_seq_fsm #(
  parameter int N   = 3,
  parameter int DIV = 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         left,
  input  logic         right,
  input  logic         hazard,
`ifdef TURN_SEQ_BRAKE_EN
  input  logic         brake,
`endif
  output logic [N-1:0] lamps_l,
  output logic [N-1:0] lamps_r,
  output logic         busy,
  output logic [7:0]   dbg_state
);

  localparam int SW = 5;
  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] DIV_LAST  = CW'(DIV - 1);
  localparam logic [SW-1:0] STEP_LAST = SW'(N);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_LSEQ = 2'd1;
  localparam logic [1:0] ST_RSEQ = 2'd2;
  localparam logic [1:0] ST_HAZ  = 2'd3;

  logic [CW-1:0] div_cnt_q, div_cnt_d;
  logic [1:0]    kind_q, kind_d;
  logic [SW-1:0] step_q, step_d;
  logic          haz_off_q, haz_off_d;
  logic          tick;
  logic          hz;

  assign tick = (div_cnt_q == DIV_LAST);
  assign hz   = hazard | (left & right);

  always_comb begin
    div_cnt_d = tick ? '0 : div_cnt_q + 1'b1;
  end

  always_comb begin
    kind_d    = kind_q;
    step_d    = step_q;
    haz_off_d = haz_off_q;
    if (tick) begin
      // Marks the one-tick dark phase that follows HAZ so brake cannot fill it.
      haz_off_d = (kind_q == ST_HAZ);
      if (hz && (kind_q != ST_HAZ)) begin
        kind_d = ST_HAZ;
        step_d = '0;
      end else begin
        case (kind_q)
          ST_HAZ: begin
            kind_d = ST_IDLE;
            step_d = '0;
          end
          ST_IDLE: begin
            if (left) begin
              kind_d = ST_LSEQ;
              step_d = SW'(1);
            end else if (right) begin
              kind_d = ST_RSEQ;
              step_d = SW'(1);
            end
          end
          default: begin
            if (step_q == STEP_LAST) begin
              kind_d = ST_IDLE;
              step_d = '0;
            end else begin
              step_d = step_q + 1'b1;
            end
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      div_cnt_q <= '0;
      kind_q    <= ST_IDLE;
      step_q    <= '0;
      haz_off_q <= 1'b0;
    end else begin
      div_cnt_q <= div_cnt_d;
      kind_q    <= kind_d;
      step_q    <= step_d;
      haz_off_q <= haz_off_d;
    end
  end

  logic [N-1:0] fill;
  logic [N-1:0] base_l, base_r;

  always_comb begin
    fill = '0;
    for (int i = 0; i < N; i++) begin
      fill[i] = (SW'(i) < step_q);
    end
  end

  always_comb begin
    base_l = '0;
    base_r = '0;
    case (kind_q)
      ST_LSEQ: base_l = fill;
      ST_RSEQ: base_r = fill;
      ST_HAZ: begin
        base_l = '1;
        base_r = '1;
      end
      default: ;
    endcase
  end

`ifdef TURN_SEQ_BRAKE_EN
  logic brake_show;
  assign brake_show = brake && (kind_q != ST_HAZ) && !haz_off_q;
  assign lamps_l = (brake_show && (kind_q != ST_LSEQ)) ? '1 : base_l;
  assign lamps_r = (brake_show && (kind_q != ST_RSEQ)) ? '1 : base_r;
`else
  assign lamps_l = base_l;
  assign lamps_r = base_r;
`endif

  assign busy      = (kind_q != ST_IDLE);
  assign dbg_state = {haz_off_q, kind_q, step_q};

endmodule

// File: tb/tb_turn_seq_fsm.sv
// Bench for turn_seq_fsm: N=3/DIV=1, N=3/DIV=4 and N=1/DIV=1 instances share stimulus.
module tb_turn_seq_fsm;

  logic clk;
  logic reset;
  logic left;
  logic right;
  logic hazard;
`ifdef TURN_SEQ_BRAKE_EN
  logic brake;
`endif

  logic [2:0] l_a, r_a, l_b, r_b;
  logic [0:0] l_c, r_c;
  logic       busy_a, busy_b, busy_c;
  logic [7:0] dbg_a, dbg_b, dbg_c;

  logic [6:0] obs, obs4;
  logic [2:0] obs1;
  assign obs  = {l_a, r_a, busy_a};
  assign obs4 = {l_b, r_b, busy_b};
  assign obs1 = {l_c, r_c, busy_c};

  logic [6:0] exp_q[$];
  int tests_run;
  int tests_failed;

  turn_seq_fsm #(.N(3), .DIV(1)) dut_a (
    .clk(clk), .reset(reset), .left(left), .right(right), .hazard(hazard),
`ifdef TURN_SEQ_BRAKE_EN
    .brake(brake),
`endif
    .lamps_l(l_a), .lamps_r(r_a), .busy(busy_a), .dbg_state(dbg_a)
  );

  turn_seq_fsm #(.N(3), .DIV(4)) dut_b (
    .clk(clk), .reset(reset), .left(left), .right(right), .hazard(hazard),
`ifdef TURN_SEQ_BRAKE_EN
    .brake(1'b0),
`endif
    .lamps_l(l_b), .lamps_r(r_b), .busy(busy_b), .dbg_state(dbg_b)
  );

  turn_seq_fsm #(.N(1), .DIV(1)) dut_c (
    .clk(clk), .reset(reset), .left(left), .right(right), .hazard(hazard),
`ifdef TURN_SEQ_BRAKE_EN
    .brake(1'b0),
`endif
    .lamps_l(l_c), .lamps_r(r_c), .busy(busy_c), .dbg_state(dbg_c)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // driver: stim = {reset, left, right, hazard}; outputs settle #1 after the edge
  task automatic cycle(input logic [3:0] stim);
    @(negedge clk);
    reset  = stim[3];
    left   = stim[2];
    right  = stim[1];
    hazard = stim[0];
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    cycle(4'b0000);
  endtask

  task automatic test_reset();
    logic [3:0] stim [5];
    logic [6:0] expv [5];
    logic [6:0] e;
    stim = '{4'b0100, 4'b0100, 4'b1100, 4'b1000, 4'b0000};
    expv = '{7'b000_000_0, 7'b000_000_0, 7'b001_000_1, 7'b011_000_1, 7'b000_000_0};
    for (int i = 0; i < 5; i++) begin
      exp_q.push_back(expv[i]);
      cycle(stim[i]);
      e = exp_q.pop_front();
      tests_run++;
      if (obs !== e) begin
        tests_failed++;
        $display("FAIL reset[%0d] got %b expected %b", i, obs, e);
      end
    end
  endtask

  task automatic test_left_seq();
    logic [3:0] stim [13];
    logic [6:0] expv [13];
    logic [6:0] e;
    do_reset();
    // single pulse, then held
    stim = '{4'b1100, 4'b1000, 4'b1000, 4'b1000, 4'b1000,
             4'b1100, 4'b1100, 4'b1100, 4'b1100, 4'b1100, 4'b1100, 4'b1100, 4'b1100};
    expv = '{7'b001_000_1, 7'b011_000_1, 7'b111_000_1, 7'b000_000_0, 7'b000_000_0,
             7'b001_000_1, 7'b011_000_1, 7'b111_000_1, 7'b000_000_0,
             7'b001_000_1, 7'b011_000_1, 7'b111_000_1, 7'b000_000_0};
    for (int i = 0; i < 13; i++) begin
      exp_q.push_back(expv[i]);
      cycle(stim[i]);
      e = exp_q.pop_front();
      tests_run++;
      if (obs !== e) begin
        tests_failed++;
        $display("FAIL left_seq[%0d] got %b expected %b", i, obs, e);
      end
    end
  endtask

  task automatic test_hazard_abort();
    logic [3:0] stim [9];
    logic [6:0] expv [9];
    logic [6:0] e;
    do_reset();
    stim = '{4'b1010, 4'b1000, 4'b1001, 4'b1001, 4'b1001, 4'b1000, 4'b1000,
             4'b1001, 4'b0001};
    expv = '{7'b000_001_1, 7'b000_011_1, 7'b111_111_1, 7'b000_000_0, 7'b111_111_1,
             7'b000_000_0, 7'b000_000_0, 7'b111_111_1, 7'b000_000_0};
    for (int i = 0; i < 9; i++) begin
      exp_q.push_back(expv[i]);
      cycle(stim[i]);
      e = exp_q.pop_front();
      tests_run++;
      if (obs !== e) begin
        tests_failed++;
        $display("FAIL hazard_abort[%0d] got %b expected %b", i, obs, e);
      end
    end
  endtask

  task automatic test_left_right();
    logic [3:0] stim [10];
    logic [6:0] expv [10];
    logic [6:0] e;
    do_reset();
    // both sides together act as hazard; then opposite-side request is ignored mid-sequence
    stim = '{4'b1110, 4'b1110, 4'b1110, 4'b1110, 4'b1000,
             4'b1100, 4'b1010, 4'b1010, 4'b1010, 4'b1010};
    expv = '{7'b111_111_1, 7'b000_000_0, 7'b111_111_1, 7'b000_000_0, 7'b000_000_0,
             7'b001_000_1, 7'b011_000_1, 7'b111_000_1, 7'b000_000_0, 7'b000_001_1};
    for (int i = 0; i < 10; i++) begin
      exp_q.push_back(expv[i]);
      cycle(stim[i]);
      e = exp_q.pop_front();
      tests_run++;
      if (obs !== e) begin
        tests_failed++;
        $display("FAIL left_right[%0d] got %b expected %b", i, obs, e);
      end
    end
  endtask

  task automatic test_prescaler();
    logic [2:0] pat [4];
    logic [6:0] e;
    int ph;
    pat = '{3'b000, 3'b001, 3'b011, 3'b111};
    do_reset();
    // left held: first tick on the 4th edge after release, each pattern lasts 4 cycles
    for (int i = 1; i <= 20; i++) begin
      ph = (i / 4) % 4;
      exp_q.push_back({pat[ph], 3'b000, ph != 0});
      cycle(4'b1100);
      e = exp_q.pop_front();
      tests_run++;
      if (obs4 !== e) begin
        tests_failed++;
        $display("FAIL prescaler_hold[%0d] got %b expected %b", i, obs4, e);
      end
    end
    do_reset();
    // right pulse between ticks is missed; one landing on a tick is taken
    for (int i = 1; i <= 16; i++) begin
      if (i == 16)      exp_q.push_back(7'b000_011_1);
      else if (i >= 12) exp_q.push_back(7'b000_001_1);
      else              exp_q.push_back(7'b000_000_0);
      cycle(((i == 2) || (i == 12)) ? 4'b1010 : 4'b1000);
      e = exp_q.pop_front();
      tests_run++;
      if (obs4 !== e) begin
        tests_failed++;
        $display("FAIL prescaler_pulse[%0d] got %b expected %b", i, obs4, e);
      end
    end
  endtask

  task automatic test_n1();
    logic [3:0] stim [7];
    logic [2:0] expv [7];
    logic [6:0] e;
    do_reset();
    stim = '{4'b1100, 4'b1100, 4'b1100, 4'b1100, 4'b1010, 4'b1000, 4'b1001};
    expv = '{3'b101, 3'b000, 3'b101, 3'b000, 3'b011, 3'b000, 3'b111};
    for (int i = 0; i < 7; i++) begin
      exp_q.push_back({4'b0000, expv[i]});
      cycle(stim[i]);
      e = exp_q.pop_front();
      tests_run++;
      if ({4'b0000, obs1} !== e) begin
        tests_failed++;
        $display("FAIL n1[%0d] got %b expected %b", i, obs1, e[2:0]);
      end
    end
  endtask

`ifdef TURN_SEQ_BRAKE_EN
  task automatic test_brake();
    logic [3:0] stim [8];
    logic [6:0] expv [8];
    logic [6:0] e;
    do_reset();
    brake = 1'b1;
    stim = '{4'b1000, 4'b1100, 4'b1000, 4'b1000, 4'b1000, 4'b1001, 4'b1001, 4'b1000};
    expv = '{7'b111_111_0, 7'b001_111_1, 7'b011_111_1, 7'b111_111_1, 7'b111_111_0,
             7'b111_111_1, 7'b000_000_0, 7'b111_111_0};
    for (int i = 0; i < 8; i++) begin
      exp_q.push_back(expv[i]);
      cycle(stim[i]);
      e = exp_q.pop_front();
      tests_run++;
      if (obs !== e) begin
        tests_failed++;
        $display("FAIL brake[%0d] got %b expected %b", i, obs, e);
      end
    end
    brake = 1'b0;
  endtask
`endif

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    reset  = 1'b0;
    left   = 1'b0;
    right  = 1'b0;
    hazard = 1'b0;
`ifdef TURN_SEQ_BRAKE_EN
    brake  = 1'b0;
`endif
    test_reset();
    test_left_seq();
    test_hazard_abort();
    test_left_right();
    test_prescaler();
    test_n1();
`ifdef TURN_SEQ_BRAKE_EN
    test_brake();
`endif
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/turn_seq_fsm.md
# turn_seq_fsm

Parametrised sequential turn-signal controller for N lamps per side, with hazard mode and a programmable step prescaler. It drives the rear lamp banks of the lights subsystem and supersedes the fixed 3-lamp-per-side light FSM. The lamp pattern advances only on prescaler ticks, so the same block can run from a fast system clock.

## Interface
Parameters:
- N, 3, lamps per side; legal range 1..16. Lamp 0 is innermost.
- DIV, 1, clk cycles per animation step; legal range 1..65535.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-low: a sampled 0 resets the block.
- left  input  1  left turn request, level-sensitive.
- right  input  1  right turn request, level-sensitive.
- hazard  input  1  hazard request, level-sensitive.
- lamps_l  output  N  left lamp bank; bit k is lamp k.
- lamps_r  output  N  right lamp bank.
- busy  output  1  high in any state other than IDLE.

## Operation
- Prescaler:
  - Counter `div_cnt` counts 0..DIV-1 and wraps to 0.
  - `tick` = (`div_cnt` == DIV-1). With DIV=1, `tick` is high every cycle.
- States: IDLE, L(k) and R(k) for k=1..N, and HAZ.
- Output decode from state:
  - IDLE: all lamps off.
  - L(k): lamps_l[k-1:0]=1, all other lamps off.
  - R(k): lamps_r[k-1:0]=1, all other lamps off.
  - HAZ: all 2N lamps on.
- Define hz = hazard | (left & right).
- Transitions occur only on a tick. Priority is listed top down:
  - hz in any state except HAZ -> HAZ. This aborts an in-flight L/R sequence.
  - HAZ -> IDLE unconditionally. With hz held, the result is a 1:1 on/off flash with a period of 2 ticks.
  - IDLE with left -> L(1). IDLE with right -> R(1). IDLE with neither stays in IDLE.
  - L(k) -> L(k+1) for k<N. L(N) -> IDLE. R(k) follows the same rule.
  - Once started, a sequence runs to completion regardless of left/right.
  - A request held continuously re-fires from IDLE. The cycle period is N+1 ticks, including one all-off tick.
  - An opposite-side request during a sequence is ignored until IDLE.
- Without a tick, state holds.

## Timing
- Reset (reset=0 at a clk edge):
  - Next cycle: state=IDLE, div_cnt=0, lamps_l=0, lamps_r=0, busy=0.
  - Reset overrides any tick in the same cycle.
  - Reset mid-sequence or mid-HAZ goes directly to IDLE. No partial pattern survives.
- Inputs are sampled only at the clk edge where tick=1. Pulses shorter than DIV cycles between ticks are missed, by design.
- Outputs are combinational decodes of registered state, so they are glitch-free relative to clk. A lamp change is visible one cycle after the tick edge.
- After reset release with DIV=D, the first tick is in cycle D-1 counted from release, and the first lamp appears on the following cycle.
- N=1: L(1) -> IDLE, giving a 2-tick flash per side.

## Configuration
- Macro `TURN_SEQ_BRAKE_EN`.
- Defined:
  - Adds an input port `brake` (1 bit).
  - While brake=1, a side that is not animating shows all lamps on. In IDLE, that means both sides.
  - The side in L(k)/R(k) shows its normal sequence.
  - In HAZ and in the HAZ off-phase, brake is ignored and the hazard pattern wins.
  - Brake is combinational on outputs and does not affect state or busy.
- Undefined: no `brake` port, and behaviour is exactly as described above.

## Test plan
All scenarios use N=3 and DIV=1 unless noted.
- **Reset:** hold reset=0 for 2 cycles with left=1, then release.
  - Outputs are 000/000 and busy=0 during reset.
  - The cycle after release shows lamps_l=001.
- **Left sequence:** pulse left for 1 cycle from IDLE.
  - lamps_l goes 001, 011, 111, 000 on consecutive cycles, then stays 000. lamps_r stays 000.
  - Hold left instead: the pattern repeats every 4 cycles.
- **Hazard abort:** start right, then assert hazard while in R(2).
  - Next cycle both banks show 111.
  - Hold hazard: both banks alternate 111/000 each cycle.
  - Release in HAZ: the next state is IDLE and busy=0.
- **left & right:** assert both together from IDLE. The response is identical to hazard (both banks 111/000 alternating).
- **Prescaler:** DIV=4, hold left.
  - Each lamp pattern persists exactly 4 cycles.
  - A 1-cycle right pulse between ticks produces no right activity.
- **Brake (`TURN_SEQ_BRAKE_EN`):**
  - brake=1 in IDLE: both banks 111.
  - Add left: lamps_l sequences 001/011/111/000 while lamps_r stays 111.
  - Add hazard: the flash pattern overrides brake.
